// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin APB master front end
// shares one APB bus between NUM_REQ requesters
module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [GW-1:0] LAST = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       grant_d;
  logic [GW-1:0]       pick;
  logic [GW-1:0]       cand;
  logic                pick_vld;
  logic [CW-1:0]       wait_cnt;
  logic [CW-1:0]       cnt_d;
  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  ack_d;
  logic                psel_d;
  logic                pen_d;
  logic                pwrite_d;
  logic                err_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [DATA_W-1:0]   pwdata_d;
  logic [DATA_W-1:0]   rdata_d;

  assign elig = req & ~ack;

  // first eligible requester after last_grant, wrapping
  always_comb begin
    pick_vld = 1'b0;
    pick     = last_grant;
    cand     = last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // next state and next registered outputs
  always_comb begin
    state_d  = state;
    grant_d  = last_grant;
    cnt_d    = wait_cnt;
    psel_d   = PSEL;
    pen_d    = PENABLE;
    pwrite_d = PWRITE;
    paddr_d  = PADDR;
    pwdata_d = PWDATA;
    rdata_d  = rdata;
    err_d    = err;
    ack_d    = '0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_d  = SETUP;
          grant_d  = pick;
          paddr_d  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata[int'(pick)*DATA_W +: DATA_W];
          pwrite_d = req_write[pick];
          psel_d   = 1'b1;
          pen_d    = 1'b0;
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d             = 1'b0;
          pen_d              = 1'b0;
          ack_d[last_grant]  = 1'b1;
          err_d              = 1'b0;
          if (!PWRITE) begin
            rdata_d = PRDATA;
          end
          state_d = IDLE;
        end else if (wait_cnt == CMAX) begin
          psel_d             = 1'b0;
          pen_d              = 1'b0;
          ack_d[last_grant]  = 1'b1;
          err_d              = 1'b1;
          state_d            = IDLE;
        end else begin
          cnt_d = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_grant <= LAST;
      wait_cnt   <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      ack        <= '0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      last_grant <= grant_d;
      wait_cnt   <= cnt_d;
      PSEL       <= psel_d;
      PENABLE    <= pen_d;
      PWRITE     <= pwrite_d;
      PADDR      <= paddr_d;
      PWDATA     <= pwdata_d;
      ack        <= ack_d;
      rdata      <= rdata_d;
      err        <= err_d;
    end
  end

endmodule
